// File: rtl/lcd_text_ctrl_if.sv
// Content-side handshake (start/text -> busy/done/init_done) plus the LCD pin bundle.
// The content logic is the master; lcd_text_ctrl is the slave.
interface lcd_text_ctrl_if #(
    parameter int TEXT_LEN = 32
);
    logic                    start;
    logic [8*TEXT_LEN-1:0]   text;
    logic                    busy;
    logic                    done;
    logic                    init_done;
    logic [4:0]              lcd_d;
    logic                    lcd_e;

    modport master (
        output start, text,
        input  busy, done, init_done, lcd_d, lcd_e
    );

    modport slave (
        input  start, text,
        output busy, done, init_done, lcd_d, lcd_e
    );
endinterface

// File: rtl/lcd_text_ctrl.sv
// HD44780 4-bit controller: power-up wait, 14-nibble init, then HOME + TEXT_LEN chars per start.
// Define LCD_NEWLINE_EN to turn byte 0x0A into a set-DDRAM-address(LINE2_ADDR) command.
module lcd_text_ctrl #(
    parameter int         FREQ_HZ    = 50_000_000,
    parameter int         TEXT_LEN   = 32,
    parameter logic [6:0] LINE2_ADDR = 7'h40,
    parameter int         PWR_UP_US  = 15000
) (
    input logic           clk_i,
    input logic           rst_ni,
    lcd_text_ctrl_if.slave bus
);
`ifdef LCD_NEWLINE_EN
    localparam bit NEWLINE_EN = 1'b1;
`else
    localparam bit NEWLINE_EN = 1'b0;
`endif

    localparam int T1US    = (FREQ_HZ / 1_000_000 < 1) ? 1 : FREQ_HZ / 1_000_000;
    localparam int PWR_CYC = (PWR_UP_US * T1US < 1) ? 1 : PWR_UP_US * T1US;
    // Wide enough for the longest of power-up and init delays so nothing wraps.
    localparam int MAX_DLY = (PWR_CYC > 4100 * T1US) ? PWR_CYC : 4100 * T1US;
    localparam int CW      = $clog2(MAX_DLY + 1);
    localparam int NW      = $clog2((2 * TEXT_LEN > 14) ? 2 * TEXT_LEN : 14);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [NW-1:0] idx_t;

    localparam cnt_t PWR_TERM = cnt_t'(PWR_CYC - 1);
    localparam cnt_t T1_TERM  = cnt_t'(T1US - 1);
    localparam cnt_t D10      = cnt_t'(10 * T1US - 1);
    localparam cnt_t D53      = cnt_t'(53 * T1US - 1);
    localparam cnt_t D100     = cnt_t'(100 * T1US - 1);
    localparam cnt_t D3M      = cnt_t'(3000 * T1US - 1);
    localparam cnt_t D4M1     = cnt_t'(4100 * T1US - 1);
    localparam idx_t LAST_NIB = idx_t'(2 * TEXT_LEN - 1);

    typedef enum logic [2:0] {S_PWR_WAIT, S_INIT, S_IDLE, S_HOME, S_TEXT} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

    state_t                state_q, state_d, nxt_st;
    phase_t                phase_q, phase_d;
    cnt_t                  cnt_q, cnt_d;
    idx_t                  idx_q, idx_d, nxt_idx;
    logic [4:0]            lcd_d_q, lcd_d_d;
    logic                  lcd_e_q, lcd_e_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  init_done_q, init_done_d;
    logic [8*TEXT_LEN-1:0] text_q, text_d;
    logic                  adv;

    function automatic logic [4:0] nib_of(state_t st, idx_t idx, logic [8*TEXT_LEN-1:0] txt);
        logic [7:0] ch;
        nib_of = 5'h00;
        ch     = 8'h00;
        case (st)
            S_INIT: begin
                case (int'(idx))
                    0, 1, 2: nib_of = 5'h03;
                    3, 4:    nib_of = 5'h02;
                    5, 13:   nib_of = 5'h0C;
                    7:       nib_of = 5'h08;
                    9:       nib_of = 5'h01;
                    11:      nib_of = 5'h06;
                    default: nib_of = 5'h00;
                endcase
            end
            S_HOME: nib_of = idx[0] ? 5'h00 : 5'h08;
            S_TEXT: begin
                ch = txt[8*(TEXT_LEN - 1 - int'(idx >> 1)) +: 8];
                if (NEWLINE_EN && ch == 8'h0A)
                    nib_of = idx[0] ? {1'b0, LINE2_ADDR[3:0]} : {2'b01, LINE2_ADDR[6:4]};
                else
                    nib_of = idx[0] ? {1'b1, ch[3:0]} : {1'b1, ch[7:4]};
            end
            default: nib_of = 5'h00;
        endcase
    endfunction

    function automatic cnt_t dly_of(state_t st, idx_t idx);
        dly_of = idx[0] ? D53 : D10;
        if (st == S_INIT) begin
            case (int'(idx))
                0:        dly_of = D4M1;
                1, 2, 3:  dly_of = D100;
                9:        dly_of = D3M;
                default:  dly_of = idx[0] ? D53 : D10;
            endcase
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        lcd_d_d     = lcd_d_q;
        lcd_e_d     = lcd_e_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        init_done_d = init_done_q;
        text_d      = text_q;
        nxt_st      = state_q;
        nxt_idx     = idx_q;
        adv         = 1'b0;

        // A start before init completes is held as pending via busy.
        if ((state_q == S_PWR_WAIT || state_q == S_INIT) && !busy_q && bus.start) begin
            busy_d = 1'b1;
            text_d = bus.text;
        end

        case (state_q)
            S_PWR_WAIT: begin
                if (cnt_q == PWR_TERM) begin
                    nxt_st  = S_INIT;
                    nxt_idx = '0;
                    adv     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (bus.start && !done_q) begin
                    busy_d  = 1'b1;
                    text_d  = bus.text;
                    nxt_st  = S_HOME;
                    nxt_idx = '0;
                    adv     = 1'b1;
                end
            end
            default: begin
                case (phase_q)
                    PH_SETUP: begin
                        phase_d = PH_PULSE;
                        lcd_e_d = 1'b1;
                        cnt_d   = '0;
                    end
                    PH_PULSE: begin
                        if (cnt_q == T1_TERM) begin
                            lcd_e_d = 1'b0;
                            phase_d = PH_WAIT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        if (cnt_q != dly_of(state_q, idx_q)) begin
                            cnt_d = cnt_q + 1'b1;
                        end else if (state_q == S_INIT && int'(idx_q) == 13) begin
                            init_done_d = 1'b1;
                            if (busy_d) begin
                                nxt_st  = S_HOME;
                                nxt_idx = '0;
                                adv     = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end else if (state_q == S_HOME && idx_q[0]) begin
                            nxt_st  = S_TEXT;
                            nxt_idx = '0;
                            adv     = 1'b1;
                        end else if (state_q == S_TEXT && idx_q == LAST_NIB) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            nxt_idx = idx_q + 1'b1;
                            adv     = 1'b1;
                        end
                    end
                endcase
            end
        endcase

        if (adv) begin
            state_d = nxt_st;
            idx_d   = nxt_idx;
            phase_d = PH_SETUP;
            cnt_d   = '0;
            lcd_d_d = nib_of(nxt_st, nxt_idx, text_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_PWR_WAIT;
            phase_q     <= PH_SETUP;
            cnt_q       <= '0;
            idx_q       <= '0;
            lcd_d_q     <= 5'h00;
            lcd_e_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            init_done_q <= 1'b0;
            text_q      <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            lcd_d_q     <= lcd_d_d;
            lcd_e_q     <= lcd_e_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            init_done_q <= init_done_d;
            text_q      <= text_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.init_done = init_done_q;
    assign bus.lcd_d     = lcd_d_q;
    assign bus.lcd_e     = lcd_e_q;
endmodule
